// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state encodings,
// latched opcode classes and the ALUOp / ALUSrcB / PCSource codes.
package multicycle_pkg;

  // Instruction opcodes (OP field)
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Controller states; codes 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_I_EXEC    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_e;

  // Opcode class captured in DECODE and used by the later states
  typedef enum logic [3:0] {
    CLS_NONE = 4'd0,
    CLS_LW   = 4'd1,
    CLS_SW   = 4'd2,
    CLS_R    = 4'd3,
    CLS_ADDI = 4'd4,
    CLS_ANDI = 4'd5,
    CLS_ORI  = 4'd6,
    CLS_LUI  = 4'd7,
    CLS_BEQ  = 4'd8,
    CLS_BNE  = 4'd9,
    CLS_J    = 4'd10
  } op_class_e;

  // ALU operation codes
  localparam logic [2:0] ALUOP_NONE  = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_SUB   = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] ALUSRCB_REGB = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Map a raw opcode to its class; unknown opcodes give CLS_NONE
  function automatic op_class_e classify_op(input logic [5:0] op);
    op_class_e cls;
    case (op)
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_R:    cls = CLS_R;
      OP_ADDI: cls = CLS_ADDI;
      OP_ANDI: cls = CLS_ANDI;
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_aluop_decode.sv
// ALUOp selection for the I_EXEC state, driven by the latched opcode class.
module multicycle_aluop_decode
  import multicycle_pkg::*;
(
  input  op_class_e  op_class,
  output logic [2:0] alu_op
);

  // Immediate-type class to ALU operation
  always_comb begin
    alu_op = ALUOP_ADD;
    case (op_class)
      CLS_ADDI: alu_op = ALUOP_ADD;
      CLS_ANDI: alu_op = ALUOP_AND;
      CLS_ORI:  alu_op = ALUOP_OR;
      CLS_LUI:  alu_op = ALUOP_LUI;
      default:  alu_op = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM (Moore). Outputs decode from the
// registered state; the only input-dependent terms are PCWrite in BRANCH
// (Zero) and, when MULTICYCLE_MEM_READY_EN is defined, the MemReady
// handshake that stretches FETCH, MEM_READ and MEM_WRITE.
// Optional feature macro: MULTICYCLE_MEM_READY_EN.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       Zero,
`ifdef MULTICYCLE_MEM_READY_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_e     state_r, state_nxt;
  op_class_e  cls_r, cls_nxt;
  logic       illegal_r, illegal_nxt;
  // Low from reset until the first edge after release, so outputs stay quiet
  // and the first FETCH cycle starts cleanly on that edge.
  logic       run_r;
  logic       mem_ready_s;
  logic [2:0] alu_op_i_s;

`ifdef MULTICYCLE_MEM_READY_EN
  assign mem_ready_s = MemReady;
`else
  assign mem_ready_s = 1'b1;
`endif

  multicycle_aluop_decode u_aluop_decode (
    .op_class (cls_r),
    .alu_op   (alu_op_i_s)
  );

  // State, opcode class, illegal-op flag and run-enable registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      cls_r     <= CLS_NONE;
      illegal_r <= 1'b0;
      run_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cls_r     <= cls_nxt;
      illegal_r <= illegal_nxt;
      run_r     <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state_r;
    cls_nxt     = cls_r;
    illegal_nxt = 1'b0;
    if (!run_r) begin
      state_nxt = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (mem_ready_s) state_nxt = ST_DECODE;
          else             state_nxt = ST_FETCH;
        end
        ST_DECODE: begin
          cls_nxt = classify_op(OP);
          case (classify_op(OP))
            CLS_LW, CLS_SW:                       state_nxt = ST_MEM_ADDR;
            CLS_R:                                state_nxt = ST_R_EXEC;
            CLS_ADDI, CLS_ANDI, CLS_ORI, CLS_LUI: state_nxt = ST_I_EXEC;
            CLS_BEQ, CLS_BNE:                     state_nxt = ST_BRANCH;
            CLS_J:                                state_nxt = ST_JUMP;
            default: begin
              state_nxt   = ST_FETCH;
              illegal_nxt = 1'b1;
            end
          endcase
        end
        ST_MEM_ADDR: begin
          if (cls_r == CLS_SW) state_nxt = ST_MEM_WRITE;
          else                 state_nxt = ST_MEM_READ;
        end
        ST_MEM_READ: begin
          if (mem_ready_s) state_nxt = ST_MEM_WB;
          else             state_nxt = ST_MEM_READ;
        end
        ST_MEM_WRITE: begin
          if (mem_ready_s) state_nxt = ST_FETCH;
          else             state_nxt = ST_MEM_WRITE;
        end
        ST_MEM_WB: state_nxt = ST_FETCH;
        ST_R_EXEC: state_nxt = ST_R_WB;
        ST_R_WB:   state_nxt = ST_FETCH;
        ST_I_EXEC: state_nxt = ST_I_WB;
        ST_I_WB:   state_nxt = ST_FETCH;
        ST_BRANCH: state_nxt = ST_FETCH;
        ST_JUMP:   state_nxt = ST_FETCH;
        default:   state_nxt = ST_FETCH;
      endcase
    end
  end

  // Output decode from registered state; everything unlisted stays 0
  always_comb begin
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = ALUSRCB_REGB;
    PCSource  = PCSRC_ALU;
    ALUOp     = ALUOP_NONE;
    IllegalOp = 1'b0;
    if (!run_r) begin
      IllegalOp = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          MemRead   = 1'b1;
          IRWrite   = mem_ready_s;
          PCWrite   = mem_ready_s;
          ALUSrcB   = ALUSRCB_FOUR;
          ALUOp     = ALUOP_ADD;
          IllegalOp = illegal_r;
        end
        ST_DECODE: begin
          ALUSrcB = ALUSRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        ST_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUSRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        ST_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_RTYPE;
        end
        ST_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUSRCB_IMM;
          ALUOp   = alu_op_i_s;
        end
        ST_I_WB: begin
          RegWrite = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_SUB;
          PCSource = PCSRC_ALUOUT;
          if (cls_r == CLS_BNE) PCWrite = !Zero;
          else                  PCWrite = Zero;
        end
        ST_JUMP: begin
          PCSource = PCSRC_JUMP;
          PCWrite  = 1'b1;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

  assign State = state_r;

endmodule
